// File: rtl/rv_pkg.sv
// Shared constants and FSM state encoding for the register-file dump engine.
// Revision: 1.0
`default_nettype none

package rv_pkg;

  localparam int RF_DATA_W   = 32;
  localparam int RF_ADDR_W   = 5;
  localparam int RF_NUM_REGS = 32;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_SEND  = 3'd2,
    ST_CSUM  = 3'd3,
    ST_DONE  = 3'd4
  } dump_state_e;

endpackage

`default_nettype wire

// File: rtl/dump_addr_gen.sv
// Pointer/end registers for the dump range, with modulo-NUM_REGS increment and end compare.
// Revision: 1.0
`default_nettype none

module dump_addr_gen
  import rv_pkg::*;
#(
  parameter int ADDR_W   = RF_ADDR_W,
  parameter int NUM_REGS = RF_NUM_REGS
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_load,
  input  logic [ADDR_W-1:0] i_first,
  input  logic [ADDR_W-1:0] i_last,
  input  logic              i_advance,
  output logic [ADDR_W-1:0] o_ptr,
  output logic              o_at_end
);

  localparam logic [ADDR_W-1:0] TOP_ADDR = ADDR_W'(NUM_REGS - 1);

  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [ADDR_W-1:0] end_q, end_d;

  always_comb begin
    ptr_d = ptr_q;
    end_d = end_q;
    if (i_load) begin
      ptr_d = i_first;
      end_d = i_last;
    end else if (i_advance) begin
      ptr_d = (ptr_q == TOP_ADDR) ? '0 : ptr_q + ADDR_W'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      ptr_q <= '0;
      end_q <= '0;
    end else begin
      ptr_q <= ptr_d;
      end_q <= end_d;
    end
  end

  assign o_ptr    = ptr_q;
  assign o_at_end = (ptr_q == end_q);

endmodule

`default_nettype wire

// File: rtl/regfile_dump.sv
// Debug snapshot engine: reads a register range through a spare RF port and streams it out.
// Optional trailing XOR checksum word when REGFILE_DUMP_CHECKSUM_EN is defined. Revision: 1.0
`default_nettype none

module regfile_dump
  import rv_pkg::*;
#(
  parameter int DATA_W   = RF_DATA_W,
  parameter int ADDR_W   = RF_ADDR_W,
  parameter int NUM_REGS = RF_NUM_REGS
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic [ADDR_W-1:0] i_first_addr,
  input  logic [ADDR_W-1:0] i_last_addr,
  output logic [ADDR_W-1:0] o_rf_addr,
  input  logic [DATA_W-1:0] i_rf_data,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [DATA_W-1:0] o_data,
  output logic [ADDR_W-1:0] o_addr,
  output logic              o_last,
  output logic              o_csum,
  output logic              o_busy,
  output logic              o_done
);

  dump_state_e       state_q, state_d;
  logic              valid_q, valid_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              last_q, last_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              load, advance;
  logic [ADDR_W-1:0] ptr;
  logic              at_end;
  logic              accept;

`ifdef REGFILE_DUMP_CHECKSUM_EN
  logic              csum_q, csum_d;
  logic [DATA_W-1:0] acc_q, acc_d;
`endif

  dump_addr_gen #(
    .ADDR_W   (ADDR_W),
    .NUM_REGS (NUM_REGS)
  ) u_addr_gen (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_load    (load),
    .i_first   (i_first_addr),
    .i_last    (i_last_addr),
    .i_advance (advance),
    .o_ptr     (ptr),
    .o_at_end  (at_end)
  );

  assign accept = valid_q && i_ready;

  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    data_d  = data_q;
    addr_d  = addr_q;
    last_d  = last_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    load    = 1'b0;
    advance = 1'b0;
`ifdef REGFILE_DUMP_CHECKSUM_EN
    csum_d  = csum_q;
    acc_d   = acc_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          load    = 1'b1;
          busy_d  = 1'b1;
          state_d = ST_FETCH;
`ifdef REGFILE_DUMP_CHECKSUM_EN
          acc_d   = '0;
`endif
        end
      end
      ST_FETCH: begin
        data_d  = i_rf_data;
        addr_d  = ptr;
        valid_d = 1'b1;
`ifdef REGFILE_DUMP_CHECKSUM_EN
        // The checksum word carries o_last, so register words never do.
        last_d  = 1'b0;
`else
        last_d  = at_end;
`endif
        state_d = ST_SEND;
      end
      ST_SEND: begin
        if (accept) begin
          valid_d = 1'b0;
          last_d  = 1'b0;
`ifdef REGFILE_DUMP_CHECKSUM_EN
          acc_d   = acc_q ^ data_q;
`endif
          if (at_end) begin
`ifdef REGFILE_DUMP_CHECKSUM_EN
            // Present the checksum immediately, folding in the word just accepted.
            valid_d = 1'b1;
            data_d  = acc_q ^ data_q;
            addr_d  = '0;
            last_d  = 1'b1;
            csum_d  = 1'b1;
            state_d = ST_CSUM;
`else
            state_d = ST_DONE;
`endif
          end else begin
            advance = 1'b1;
            state_d = ST_FETCH;
          end
        end
      end
`ifdef REGFILE_DUMP_CHECKSUM_EN
      ST_CSUM: begin
        if (accept) begin
          valid_d = 1'b0;
          last_d  = 1'b0;
          csum_d  = 1'b0;
          state_d = ST_DONE;
        end
      end
`endif
      ST_DONE: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      state_q <= ST_IDLE;
      valid_q <= 1'b0;
      data_q  <= '0;
      addr_q  <= '0;
      last_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      addr_q  <= addr_d;
      last_q  <= last_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

`ifdef REGFILE_DUMP_CHECKSUM_EN
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      csum_q <= 1'b0;
      acc_q  <= '0;
    end else begin
      csum_q <= csum_d;
      acc_q  <= acc_d;
    end
  end
  assign o_csum = csum_q;
`else
  assign o_csum = 1'b0;
`endif

  assign o_rf_addr = ptr;
  assign o_valid   = valid_q;
  assign o_data    = data_q;
  assign o_addr    = addr_q;
  assign o_last    = last_q;
  assign o_busy    = busy_q;
  assign o_done    = done_q;

endmodule

`default_nettype wire

// File: tb/tb_regfile_dump.sv
// Self-checking bench for regfile_dump: randomized ranges/backpressure against a word-list reference.
`default_nettype none

module tb_regfile_dump;

  typedef struct {
    logic [4:0]  addr;
    logic [31:0] data;
    bit          last;
    bit          csum;
  } word_t;

  logic        clk = 1'b0;
  logic        i_rst;
  logic        i_start;
  logic [4:0]  i_first_addr;
  logic [4:0]  i_last_addr;
  logic [4:0]  o_rf_addr;
  logic [31:0] i_rf_data;
  logic        o_valid;
  logic        i_ready;
  logic [31:0] o_data;
  logic [4:0]  o_addr;
  logic        o_last;
  logic        o_csum;
  logic        o_busy;
  logic        o_done;

  logic [31:0] rf [32];
  int          n_checks = 0;
  int          n_errors = 0;

  always #5 clk = ~clk;

  regfile_dump dut (
    .i_clk        (clk),
    .i_rst        (i_rst),
    .i_start      (i_start),
    .i_first_addr (i_first_addr),
    .i_last_addr  (i_last_addr),
    .o_rf_addr    (o_rf_addr),
    .i_rf_data    (i_rf_data),
    .o_valid      (o_valid),
    .i_ready      (i_ready),
    .o_data       (o_data),
    .o_addr       (o_addr),
    .o_last       (o_last),
    .o_csum       (o_csum),
    .o_busy       (o_busy),
    .o_done       (o_done)
  );

  function automatic logic [31:0] rd(input logic [4:0] a);
    return (a == 5'd0) ? 32'd0 : rf[a];
  endfunction

  always_comb i_rf_data = rd(o_rf_addr);

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // mode 0: always ready, 1: ready pattern 0,0,1, 2: random ready
  task automatic run_dump(input logic [4:0] first, input logic [4:0] last, input int mode,
                          input bit poke, input bit glitch);
    word_t       exp_q[$];
    word_t       w;
    word_t       held_w;
    logic [31:0] acc;
    int          n, idx, cyc, hs_cyc, done_cyc, done_cnt;
    bit          held, poked, busy_at_done;

    n   = ((int'(last) - int'(first) + 32) % 32) + 1;
    acc = 32'd0;
    for (int k = 0; k < n; k++) begin
      w.addr = 5'((int'(first) + k) % 32);
      w.data = rd(w.addr);
      w.last = (k == n - 1);
      w.csum = 1'b0;
      acc    = acc ^ w.data;
`ifdef REGFILE_DUMP_CHECKSUM_EN
      w.last = 1'b0;
`endif
      exp_q.push_back(w);
    end
`ifdef REGFILE_DUMP_CHECKSUM_EN
    w.addr = 5'd0;
    w.data = acc;
    w.last = 1'b1;
    w.csum = 1'b1;
    exp_q.push_back(w);
`endif

    i_start      = 1'b1;
    i_first_addr = first;
    i_last_addr  = last;
    @(negedge clk);
    i_start = 1'b0;
    check("busy_after_start", o_busy, 1);
    if (glitch) begin
      i_first_addr = 5'd9;
      i_last_addr  = 5'd9;
    end

    idx = 0; cyc = 0; done_cnt = 0; held = 0; poked = 0;
    hs_cyc = -100; done_cyc = 0; busy_at_done = 1'b1;
    held_w = w;
    while (cyc < 600 && done_cnt == 0) begin
      if (o_done) begin
        done_cnt++;
        done_cyc     = cyc;
        busy_at_done = o_busy;
      end
      if (held) begin
        check("hold_valid", o_valid, 1);
        check("hold_data", o_data, held_w.data);
        check("hold_addr", o_addr, held_w.addr);
        check("hold_last", o_last, held_w.last);
      end
      case (mode)
        0:       i_ready = 1'b1;
        1:       i_ready = (cyc % 3 == 2);
        default: i_ready = 1'($urandom_range(0, 1));
      endcase
      i_start = glitch && (cyc == 6);
      if (poke && !poked && o_valid && !i_ready && o_addr == 5'd3 && !o_csum) begin
        rf[3] = 32'hDEADBEEF;
        poked = 1'b1;
      end
      if (o_valid && i_ready) begin
        if (idx < exp_q.size()) begin
          check("word_addr", o_addr, exp_q[idx].addr);
          check("word_data", o_data, exp_q[idx].data);
          check("word_last", o_last, exp_q[idx].last);
          check("word_csum", o_csum, exp_q[idx].csum);
          if (idx == exp_q.size() - 1) hs_cyc = cyc;
        end else begin
          check("extra_word", 1, 0);
        end
        idx++;
      end
      held = o_valid && !i_ready;
      held_w.data = o_data;
      held_w.addr = o_addr;
      held_w.last = o_last;
      @(negedge clk);
      cyc++;
    end
    i_start = 1'b0;
    i_ready = 1'b0;
    check("done_seen", done_cnt, 1);
    check("word_count", idx, exp_q.size());
    check("done_latency", done_cyc - hs_cyc, 2);
    check("busy_at_done", busy_at_done, 0);
    if (poke) check("poke_happened", poked, 1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("no_extra_done", o_done, 0);
      check("idle_valid", o_valid, 0);
    end
  endtask

  initial begin
    i_rst = 1'b0; i_start = 1'b0; i_ready = 1'b0;
    i_first_addr = 5'd0; i_last_addr = 5'd0;
    for (int k = 0; k < 32; k++) rf[k] = 32'(k) * 32'h11111111;
    repeat (3) @(negedge clk);
    check("rst_valid", o_valid, 0);
    check("rst_busy", o_busy, 0);
    check("rst_done", o_done, 0);
    check("rst_data", o_data, 0);
    check("rst_addr", o_addr, 0);
    check("rst_rf_addr", o_rf_addr, 0);
    check("rst_csum", o_csum, 0);
    i_rst = 1'b1;
    @(negedge clk);

    // Reset in the middle of a dump while x5 is held.
    i_start = 1'b1; i_first_addr = 5'd0; i_last_addr = 5'd31;
    @(negedge clk);
    i_start = 1'b0;
    begin
      int c;
      c = 0;
      while (c < 100 && !(o_valid && o_addr == 5'd5)) begin
        i_ready = 1'b1;
        @(negedge clk);
        c++;
      end
      check("reach_x5", (o_valid && o_addr == 5'd5), 1);
    end
    i_ready = 1'b0;
    i_rst   = 1'b0;
    @(negedge clk);
    check("midrst_valid", o_valid, 0);
    check("midrst_busy", o_busy, 0);
    check("midrst_done", o_done, 0);
    i_rst = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("postrst_done", o_done, 0);
      check("postrst_valid", o_valid, 0);
    end
    run_dump(5'd0, 5'd0, 0, 0, 0);

    run_dump(5'd0, 5'd31, 0, 0, 0);   // full dump
    run_dump(5'd30, 5'd1, 0, 0, 0);   // wrap range
    run_dump(5'd7, 5'd7, 1, 0, 0);    // single word under backpressure
    run_dump(5'd1, 5'd6, 1, 1, 0);    // x3 rewritten while held
    run_dump(5'd0, 5'd15, 0, 0, 1);   // start pulse mid-dump ignored

    rf[1] = 32'h0000FFFF;
    rf[2] = 32'hFFFF0000;
    run_dump(5'd1, 5'd2, 0, 0, 0);

    for (int t = 0; t < 8; t++) begin
      for (int k = 0; k < 32; k++) rf[k] = $urandom;
      run_dump(5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
               int'($urandom_range(0, 2)), 0, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
